multi_channel_pulse_detector: RTL and testbench

Parametrised successor to the single-bit posedge and one-cycle-pulse detectors. It handles N independent input channels. Each channel has selectable edge detection (rising, falling, both, none) and measures pulse width. A pulse is reported only when its width lies in [MIN_W, MAX_W]; longer pulses are flagged separately. The block sits between synchronised status/strobe inputs and the control logic that reacts to them.

---
 rtl/multi_channel_pulse_detector.sv | 96 +++++++++
 tb/tb_multi_channel_pulse_detector.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_pulse_detector.sv
// N-channel edge detector and pulse-width qualifier: reports pulses whose width
// lies in [MIN_W, MAX_W] and flags longer ones, with selectable polarity and edge mode.
module multi_channel_pulse_detector #(
  parameter int N     = 4,
  parameter int MIN_W = 1,
  parameter int MAX_W = 1,
  localparam int WW   = $clog2(MAX_W + 2)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    a,
  input  logic            pol,
  input  logic [1:0]      edge_mode,
  output logic [N-1:0]    edge_det,
  output logic [N-1:0]    pulse_det,
  output logic [N-1:0]    overlong,
  output logic [N*WW-1:0] pulse_width
);

  localparam logic [WW-1:0] CNT_MIN = WW'(MIN_W);
  localparam logic [WW-1:0] CNT_MAX = WW'(MAX_W);
  localparam logic [WW-1:0] CNT_SAT = WW'(MAX_W + 1);

  logic [N-1:0]         prev_q;
  logic [N-1:0]         armed_q, armed_d;
  logic [N-1:0][WW-1:0] cnt_q, cnt_d;
  logic                 pol_q;

  logic [N-1:0] rise, fall;
  logic         pol_chg;

  assign rise    = a & ~prev_q;
  assign fall    = ~a & prev_q;
  assign pol_chg = (pol != pol_q);

  always_comb begin
    edge_det = '0;
    if (rst) begin
      case (edge_mode)
        2'b00:   edge_det = rise;
        2'b01:   edge_det = fall;
        2'b10:   edge_det = rise | fall;
        default: edge_det = '0;
      endcase
    end
  end

  // A pulse ends on the first idle cycle with a non-zero count; a polarity
  // change in that cycle voids it and restarts every channel unarmed.
  always_comb begin
    cnt_d       = '0;
    armed_d     = '0;
    pulse_det   = '0;
    overlong    = '0;
    pulse_width = '0;
    for (int i = 0; i < N; i++) begin
      logic active;
      logic pulse_end;
      active    = (a[i] == pol);
      pulse_end = !active && (cnt_q[i] != '0);

      if (active) begin
        cnt_d[i] = (cnt_q[i] == CNT_SAT) ? cnt_q[i] : cnt_q[i] + WW'(1);
      end else begin
        cnt_d[i] = '0;
      end
      armed_d[i] = armed_q[i] | !active;

      if (pol_chg) begin
        cnt_d[i]   = '0;
        armed_d[i] = 1'b0;
      end

      if (rst && !pol_chg && armed_q[i] && pulse_end) begin
        pulse_det[i] = (cnt_q[i] >= CNT_MIN) && (cnt_q[i] <= CNT_MAX);
        overlong[i]  = (cnt_q[i] == CNT_SAT);
      end
      pulse_width[i*WW +: WW] = pulse_det[i] ? cnt_q[i] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q  <= '0;
      armed_q <= '0;
      cnt_q   <= '0;
      pol_q   <= 1'b1;
    end else begin
      prev_q  <= a;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      pol_q   <= pol;
    end
  end

endmodule

// File: tb/tb_multi_channel_pulse_detector.sv
// Directed bench for multi_channel_pulse_detector: two instances (MIN_W=MAX_W=1
// and MIN_W=2/MAX_W=4) share stimulus; expected values are hand-derived.
module tb_multi_channel_pulse_detector;

  localparam int N    = 4;
  localparam int WW_A = 2;
  localparam int WW_B = 3;

  logic clk;
  logic rst;
  logic [N-1:0] a;
  logic pol;
  logic [1:0] edge_mode;

  logic [N-1:0]      edge_a, pulse_a, ovl_a;
  logic [N*WW_A-1:0] pw_a;
  logic [N-1:0]      edge_b, pulse_b, ovl_b;
  logic [N*WW_B-1:0] pw_b;

  int n_checks = 0;
  int n_pass   = 0;

  multi_channel_pulse_detector #(.N(N), .MIN_W(1), .MAX_W(1)) dut_a (
    .clk(clk), .rst(rst), .a(a), .pol(pol), .edge_mode(edge_mode),
    .edge_det(edge_a), .pulse_det(pulse_a), .overlong(ovl_a), .pulse_width(pw_a)
  );

  multi_channel_pulse_detector #(.N(N), .MIN_W(2), .MAX_W(4)) dut_b (
    .clk(clk), .rst(rst), .a(a), .pol(pol), .edge_mode(edge_mode),
    .edge_det(edge_b), .pulse_det(pulse_b), .overlong(ovl_b), .pulse_width(pw_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]      a;
    logic              pol;
    logic [1:0]        mode;
    logic [N-1:0]      e;
    logic [N-1:0]      p;
    logic [N-1:0]      o;
    logic [N*WW_A-1:0] pw;
  } vec_t;

  vec_t tbl[64];

  function automatic vec_t mk(logic [N-1:0] av, logic pv, logic [1:0] mv, logic [N-1:0] ev,
                              logic [N-1:0] pd, logic [N-1:0] ov, logic [N*WW_A-1:0] wv);
    vec_t v;
    v.a = av; v.pol = pv; v.mode = mv; v.e = ev; v.p = pd; v.o = ov; v.pw = wv;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Entered at posedge+1; leaves at posedge+1 with reset released, so the
  // next posedge closes cycle 0.
  task automatic do_reset(logic p);
    rst = 1'b0; a = '1; pol = p; edge_mode = 2'b10;
    @(negedge clk);
    chk("rst.edge_a",  32'(edge_a),  32'h0);
    chk("rst.pulse_a", 32'(pulse_a), 32'h0);
    chk("rst.ovl_b",   32'(ovl_b),   32'h0);
    chk("rst.pw_a",    32'(pw_a),    32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic apply(vec_t v, string tag);
    a = v.a; pol = v.pol; edge_mode = v.mode;
    @(negedge clk);
    chk({tag, ".edge"},  32'(edge_a),  32'(v.e));
    chk({tag, ".pulse"}, 32'(pulse_a), 32'(v.p));
    chk({tag, ".ovl"},   32'(ovl_a),   32'(v.o));
    chk({tag, ".width"}, 32'(pw_a),    32'(v.pw));
    @(posedge clk); #1;
  endtask

  // Width-w active-high pulse on channel 0 of dut_b, then its single end cycle.
  task automatic run_pulse_b(int w, logic ep, logic eo, logic [WW_B-1:0] ew, string tag);
    for (int k = 0; k < w; k++) begin
      a = 4'b0001;
      @(negedge clk);
      chk({tag, ".mid_pulse"}, 32'(pulse_b), 32'h0);
      chk({tag, ".mid_ovl"},   32'(ovl_b),   32'h0);
      @(posedge clk); #1;
    end
    a = 4'b0000;
    @(negedge clk);
    chk({tag, ".end_pulse"}, 32'(pulse_b[0]),      32'(ep));
    chk({tag, ".end_ovl"},   32'(ovl_b[0]),        32'(eo));
    chk({tag, ".end_width"}, 32'(pw_b[WW_B-1:0]),  32'(ew));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] a_seq, rise_s, fall_s, both_s, p_seq, o_seq, e_sel;
    a_seq  = 16'b1000111001000100;
    rise_s = 16'b1000001001000100;
    fall_s = 16'b0001000010001000;
    both_s = 16'b1001001011001100;
    p_seq  = 16'b0000000010001000;
    o_seq  = 16'b0001000000000000;
    for (int m = 0; m < 4; m++) begin
      case (m)
        0:       e_sel = rise_s;
        1:       e_sel = fall_s;
        2:       e_sel = both_s;
        default: e_sel = 16'h0;
      endcase
      for (int c = 0; c < 16; c++) begin
        tbl[m*16+c] = mk({3'b0, a_seq[c]}, 1'b1, 2'(m), {3'b0, e_sel[c]},
                         {3'b0, p_seq[c]}, {3'b0, o_seq[c]}, {7'b0, p_seq[c]});
      end
    end

    rst = 1'b0; a = '0; pol = 1'b1; edge_mode = 2'b00;
    @(posedge clk); #1;

    // Edge modes and 1-cycle pulses on channel 0
    for (int m = 0; m < 4; m++) begin
      do_reset(1'b1);
      for (int c = 0; c < 16; c++) apply(tbl[m*16+c], $sformatf("mode%0d.c%0d", m, c));
    end

    // Width qualification, MIN_W=2 MAX_W=4, including back-to-back pulses
    do_reset(1'b1);
    edge_mode = 2'b00;
    for (int k = 0; k < 2; k++) begin
      a = 4'b0000;
      @(negedge clk);
      chk("b.idle", 32'({pulse_b, ovl_b}), 32'h0);
      @(posedge clk); #1;
    end
    run_pulse_b(1, 1'b0, 1'b0, 3'd0, "b.w1");
    run_pulse_b(2, 1'b1, 1'b0, 3'd2, "b.w2");
    run_pulse_b(2, 1'b1, 1'b0, 3'd2, "b.w2_b2b");
    run_pulse_b(4, 1'b1, 1'b0, 3'd4, "b.w4");
    run_pulse_b(5, 1'b0, 1'b1, 3'd0, "b.w5");
    run_pulse_b(9, 1'b0, 1'b1, 3'd0, "b.w9");

    // Active-low pulses, idle high
    do_reset(1'b0);
    apply(mk(4'hF, 1'b0, 2'b00, 4'hF, 4'h0, 4'h0, 8'h00), "pol0.c0");
    apply(mk(4'hF, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 8'h00), "pol0.c1");
    apply(mk(4'hE, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 8'h00), "pol0.c2");
    apply(mk(4'hF, 1'b0, 2'b00, 4'h1, 4'h1, 4'h0, 8'h01), "pol0.c3");
    apply(mk(4'hE, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 8'h00), "pol0.c4");
    apply(mk(4'hE, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 8'h00), "pol0.c5");
    apply(mk(4'hF, 1'b0, 2'b00, 4'h1, 4'h0, 4'h1, 8'h00), "pol0.c6");
    apply(mk(4'hF, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0, 8'h00), "pol0.c7");

    // Pulse already active out of reset is not reported
    do_reset(1'b1);
    apply(mk(4'h1, 1'b1, 2'b00, 4'h1, 4'h0, 4'h0, 8'h00), "rstpulse.c0");
    apply(mk(4'h1, 1'b1, 2'b00, 4'h0, 4'h0, 4'h0, 8'h00), "rstpulse.c1");
    apply(mk(4'h1, 1'b1, 2'b00, 4'h0, 4'h0, 4'h0, 8'h00), "rstpulse.c2");
    apply(mk(4'h0, 1'b1, 2'b00, 4'h0, 4'h0, 4'h0, 8'h00), "rstpulse.c3");
    apply(mk(4'h1, 1'b1, 2'b00, 4'h1, 4'h0, 4'h0, 8'h00), "rstpulse.c4");
    apply(mk(4'h0, 1'b1, 2'b00, 4'h0, 4'h1, 4'h0, 8'h01), "rstpulse.c5");

    // Polarity toggle while channel 2 is mid-pulse
    do_reset(1'b1);
    apply(mk(4'b0000, 1'b1, 2'b10, 4'b0000, 4'h0, 4'h0, 8'h00), "tog.c0");
    apply(mk(4'b0000, 1'b1, 2'b10, 4'b0000, 4'h0, 4'h0, 8'h00), "tog.c1");
    apply(mk(4'b0101, 1'b1, 2'b10, 4'b0101, 4'h0, 4'h0, 8'h00), "tog.c2");
    apply(mk(4'b0100, 1'b0, 2'b10, 4'b0001, 4'h0, 4'h0, 8'h00), "tog.c3");
    apply(mk(4'b0000, 1'b0, 2'b10, 4'b0100, 4'h0, 4'h0, 8'h00), "tog.c4");
    apply(mk(4'b0100, 1'b0, 2'b10, 4'b0100, 4'h0, 4'h0, 8'h00), "tog.c5");
    apply(mk(4'b0000, 1'b0, 2'b10, 4'b0100, 4'h0, 4'h0, 8'h00), "tog.c6");
    apply(mk(4'b0100, 1'b0, 2'b10, 4'b0100, 4'b0100, 4'h0, 8'h10), "tog.c7");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
